dual_avg_trend_detector: RTL and testbench

//  Parametrised dual moving-average trend detector for physiological samples (BPM, SpO2, ...).

---
 rtl/dual_avg_trend_detector.sv | 164 ++++++++++++++++
 tb/tb_dual_avg_trend_detector.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/dual_avg_trend_detector.sv
// dual_avg_trend_detector
//   Short/long boxcar moving averages over an unsigned sample stream. The two
//   averages are compared against a fixed ratio by cross-multiplication, with
//   no dividers. A debounced flag reports a sustained rise (MODE=0) or fall
//   (MODE=1).
//
//   Optional build macro: DUAL_AVG_HYST_EN
//     defined   - once flag is set, it holds while the release test passes.
//                 The release ratio is REL_NUM/RATIO_DEN.
//     undefined - the first non-trip sample releases the flag; REL_NUM has no effect.
module dual_avg_trend_detector #(
  parameter int W         = 8,
  parameter int LOG_S     = 3,
  parameter int LOG_L     = 6,
  parameter int RATIO_NUM = 5,
  parameter int RATIO_DEN = 4,
  parameter int REL_NUM   = 9,
  parameter int MODE      = 0,
  parameter int HOLD      = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [W-1:0] in_sample,
  input  logic         clear,
  output logic         out_valid,
  output logic         warm,
  output logic [W-1:0] short_avg,
  output logic [W-1:0] long_avg,
  output logic         flag
);

  localparam int DS = 1 << LOG_S;
  localparam int DL = 1 << LOG_L;
  localparam int SW = W + LOG_S;
  localparam int LW = W + LOG_L;
  localparam int CW = W + LOG_S + LOG_L + 8;

`ifdef DUAL_AVG_HYST_EN
  localparam int REL_EFF = REL_NUM;
`else
  // Without hysteresis the release test collapses onto the trip test.
  localparam int REL_EFF = RATIO_NUM + 0 * REL_NUM;
`endif

  localparam logic [CW-1:0]  C_NUM  = CW'(RATIO_NUM);
  localparam logic [CW-1:0]  C_DEN  = CW'(RATIO_DEN);
  localparam logic [CW-1:0]  C_REL  = CW'(REL_EFF);
  localparam logic [7:0]     HOLD_C = 8'(HOLD);
  localparam logic [LOG_S:0] FULL_S = {1'b1, {LOG_S{1'b0}}};
  localparam logic [LOG_L:0] FULL_L = {1'b1, {LOG_L{1'b0}}};
  localparam logic [LOG_S:0] ONE_S  = {{LOG_S{1'b0}}, 1'b1};
  localparam logic [LOG_L:0] ONE_L  = {{LOG_L{1'b0}}, 1'b1};

  logic [W-1:0]   win_s [DS];
  logic [W-1:0]   win_l [DL];
  logic [SW-1:0]  sum_s, sum_s_next;
  logic [LW-1:0]  sum_l, sum_l_next;
  logic [LOG_S:0] fill_s, fill_s_next;
  logic [LOG_L:0] fill_l, fill_l_next;
  logic [7:0]     hold_cnt, hold_next;
  logic [CW-1:0]  a_val, b_val;
  logic           warm_now, warm_next;
  logic           trip, rel_pass, flag_next;

  // Running sums drop the oldest entry; entries are zero until the window fills.
  always_comb begin
    sum_s_next  = sum_s - SW'(win_s[DS-1]) + SW'(in_sample);
    sum_l_next  = sum_l - LW'(win_l[DL-1]) + LW'(in_sample);
    fill_s_next = (fill_s == FULL_S) ? FULL_S : fill_s + ONE_S;
    fill_l_next = (fill_l == FULL_L) ? FULL_L : fill_l + ONE_L;
    warm_now    = (fill_l == FULL_L);
    warm_next   = (fill_s_next == FULL_S) && (fill_l_next == FULL_L);
    a_val       = {{(CW-SW){1'b0}}, sum_s_next} << LOG_L;
    b_val       = {{(CW-LW){1'b0}}, sum_l_next} << LOG_S;
  end

  // Ratio tests on the post-acceptance sums, cross-multiplied to avoid division.
  always_comb begin
    trip     = 1'b0;
    rel_pass = 1'b0;
    if (MODE == 0) begin
      trip     = (a_val * C_DEN) >= (b_val * C_NUM);
      rel_pass = (a_val * C_DEN) >= (b_val * C_REL);
    end else begin
      trip     = (a_val * C_NUM) <= (b_val * C_DEN);
      rel_pass = (a_val * C_REL) <= (b_val * C_DEN);
    end
  end

  // Debounce: count consecutive trips up to HOLD; a set flag is governed by the release test.
  always_comb begin
    hold_next = hold_cnt;
    flag_next = flag;
    if (!warm_now) begin
      hold_next = 8'd0;
      flag_next = 1'b0;
    end else if (flag) begin
      if (rel_pass) begin
        hold_next = hold_cnt;
        flag_next = 1'b1;
      end else begin
        hold_next = 8'd0;
        flag_next = 1'b0;
      end
    end else if (trip) begin
      hold_next = (hold_cnt >= HOLD_C) ? HOLD_C : hold_cnt + 8'd1;
      flag_next = (hold_next == HOLD_C);
    end else begin
      hold_next = 8'd0;
      flag_next = 1'b0;
    end
  end

  // Sample windows: newest at index 0, shift on every accepted sample.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      for (int i = 0; i < DS; i++) win_s[i] <= '0;
      for (int i = 0; i < DL; i++) win_l[i] <= '0;
    end else if (in_valid) begin
      win_s[0] <= in_sample;
      win_l[0] <= in_sample;
      for (int i = 1; i < DS; i++) win_s[i] <= win_s[i-1];
      for (int i = 1; i < DL; i++) win_l[i] <= win_l[i-1];
    end
  end

  // Sums, fill counters and debounce counter advance on accepted samples only.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      sum_s    <= '0;
      sum_l    <= '0;
      fill_s   <= '0;
      fill_l   <= '0;
      hold_cnt <= 8'd0;
    end else if (in_valid) begin
      sum_s    <= sum_s_next;
      sum_l    <= sum_l_next;
      fill_s   <= fill_s_next;
      fill_l   <= fill_l_next;
      hold_cnt <= hold_next;
    end
  end

  // Registered outputs; out_valid pulses for one cycle per accepted sample.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      out_valid <= 1'b0;
      warm      <= 1'b0;
      short_avg <= '0;
      long_avg  <= '0;
      flag      <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        warm      <= warm_next;
        short_avg <= sum_s_next[SW-1:LOG_S];
        long_avg  <= sum_l_next[LW-1:LOG_L];
        flag      <= flag_next;
      end
    end
  end

endmodule

// File: tb/tb_dual_avg_trend_detector.sv
// Bench for dual_avg_trend_detector: a rise-mode and a fall-mode instance share
// one stimulus stream. A queue-based reference model supplies every expected value.
module tb_dual_avg_trend_detector;

  localparam int RN = 5;
  localparam int RD = 4;
  localparam int RL = 9;
  localparam int HOLD = 3;

  logic       clk = 1'b0;
  logic       rst, in_valid, clear;
  logic [7:0] in_sample;
  logic       ov0, warm0, fl0, ov1, warm1, fl1;
  logic [7:0] sa0, la0, sa1, la1;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  dual_avg_trend_detector #(.MODE(0)) u_rise (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sample(in_sample), .clear(clear),
    .out_valid(ov0), .warm(warm0), .short_avg(sa0), .long_avg(la0), .flag(fl0));

  dual_avg_trend_detector #(.MODE(1)) u_fall (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sample(in_sample), .clear(clear),
    .out_valid(ov1), .warm(warm1), .short_avg(sa1), .long_avg(la1), .flag(fl1));

  // Reference model: the last 64 accepted samples, newest at the back.
  int hist[$];
  int m_hold[2];
  bit m_flag[2];
  bit e_ov, e_warm;
  int e_sa, e_la;

  function automatic longint tail_sum(int n);
    longint s = 0;
    for (int i = 0; i < n && i < hist.size(); i++) s += hist[hist.size()-1-i];
    return s;
  endfunction

  task automatic model_reset();
    hist.delete();
    for (int m = 0; m < 2; m++) begin m_hold[m] = 0; m_flag[m] = 1'b0; end
    e_ov = 1'b0; e_warm = 1'b0; e_sa = 0; e_la = 0;
  endtask

  task automatic model_accept(input int s);
    bit     was_warm;
    longint ss, sl, lhs_t, rhs_t, lhs_r, rhs_r;
    bit     trip, rel;
    was_warm = (hist.size() == 64);
    hist.push_back(s);
    if (hist.size() > 64) void'(hist.pop_front());
    ss = tail_sum(8);
    sl = tail_sum(64);
    for (int m = 0; m < 2; m++) begin
      // short mean / long mean compared to RN/RD: (ss/8)/(sl/64) = 8*ss/sl
      if (m == 0) begin
        lhs_t = 8 * ss * RD; rhs_t = sl * RN; trip = lhs_t >= rhs_t;
        lhs_r = 8 * ss * RD; rhs_r = sl * RL; rel  = lhs_r >= rhs_r;
      end else begin
        lhs_t = 8 * ss * RN; rhs_t = sl * RD; trip = lhs_t <= rhs_t;
        lhs_r = 8 * ss * RL; rhs_r = sl * RD; rel  = lhs_r <= rhs_r;
      end
`ifndef DUAL_AVG_HYST_EN
      rel = trip;
`endif
      if (!was_warm) begin
        m_hold[m] = 0; m_flag[m] = 1'b0;
      end else if (m_flag[m]) begin
        if (!rel) begin m_hold[m] = 0; m_flag[m] = 1'b0; end
      end else if (trip) begin
        if (m_hold[m] < HOLD) m_hold[m]++;
        m_flag[m] = (m_hold[m] == HOLD);
      end else begin
        m_hold[m] = 0; m_flag[m] = 1'b0;
      end
    end
    e_ov = 1'b1;
    e_warm = (hist.size() == 64);
    e_sa = int'(ss / 8);
    e_la = int'(sl / 64);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string ph);
    check({ph, ".out_valid0"}, 32'(ov0), 32'(e_ov));
    check({ph, ".out_valid1"}, 32'(ov1), 32'(e_ov));
    check({ph, ".warm0"}, 32'(warm0), 32'(e_warm));
    check({ph, ".warm1"}, 32'(warm1), 32'(e_warm));
    check({ph, ".short_avg0"}, 32'(sa0), 32'(e_sa));
    check({ph, ".short_avg1"}, 32'(sa1), 32'(e_sa));
    check({ph, ".long_avg0"}, 32'(la0), 32'(e_la));
    check({ph, ".long_avg1"}, 32'(la1), 32'(e_la));
    check({ph, ".flag_rise"}, 32'(fl0), 32'(m_flag[0]));
    check({ph, ".flag_fall"}, 32'(fl1), 32'(m_flag[1]));
  endtask

  task automatic send(input string ph, input int s, input int idle);
    @(negedge clk);
    in_valid = 1'b1; in_sample = 8'(s);
    model_accept(s);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check_all(ph);
    e_ov = 1'b0;
    repeat (idle) begin
      @(posedge clk); #1;
      check_all({ph, ".idle"});
    end
  endtask

  task automatic do_clear(input bit with_sample);
    @(negedge clk);
    clear = 1'b1; in_valid = with_sample; in_sample = 8'($urandom_range(0, 255));
    @(posedge clk); #1;
    clear = 1'b0; in_valid = 1'b0;
    model_reset();
    check_all("clear");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lvl, s;
    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_sample = 8'd0;
    model_reset();
    repeat (3) @(posedge clk);
    #1; rst = 1'b0;
    check_all("reset");

    // Warm-up on a flat input
    for (int i = 0; i < 63; i++) send("t1", 80, 0);
    check("t1.warm_before_64th", 32'(warm0), 32'd0);
    send("t1", 80, 0);
    check("t1.warm_after_64th", 32'(warm0), 32'd1);
    check("t1.short_avg", 32'(sa0), 32'd80);
    check("t1.long_avg", 32'(la0), 32'd80);

    // Rise: flag on the ninth 110-sample
    for (int i = 0; i < 8; i++) send("t2", 110, 0);
    check("t2.flag_before_9th", 32'(fl0), 32'd0);
    send("t2", 110, 0);
    check("t2.flag_at_9th", 32'(fl0), 32'd1);

    // Ratio falls to about 1.29, then 1.27, then 1.248
    send("t6", 100, 0);
    send("t6", 100, 0);
    check("t6.flag_still_tripping", 32'(fl0), 32'd1);
    send("t6", 100, 0);
`ifndef DUAL_AVG_HYST_EN
    check("t6.flag_released", 32'(fl0), 32'd0);
`endif

    // Debounce abort
    do_clear(1'b0);
    for (int i = 0; i < 64; i++) send("t3", 80, 0);
    for (int i = 0; i < 7; i++) send("t3", 110, 0);
    send("t3", 80, 0);
    check("t3.flag_after_abort", 32'(fl0), 32'd0);
    send("t3", 110, 0);
    send("t3", 110, 0);

    // Clear with a coincident sample, then the rise sequence with idle gaps
    do_clear(1'b1);
    for (int i = 0; i < 63; i++) send("t4", 80, $urandom_range(0, 20));
    check("t4.warm_needs_64", 32'(warm0), 32'd0);
    send("t4", 80, $urandom_range(0, 20));
    check("t4.warm_after_64", 32'(warm0), 32'd1);
    for (int i = 0; i < 8; i++) send("t4", 110, $urandom_range(0, 20));
    check("t4.flag_before_9th", 32'(fl0), 32'd0);
    send("t4", 110, $urandom_range(0, 20));
    check("t4.flag_at_9th", 32'(fl0), 32'd1);

    // Fall detect on the MODE=1 instance
    do_clear(1'b0);
    for (int i = 0; i < 64; i++) send("t5", 80, 0);
    for (int i = 0; i < 6; i++) send("t5", 50, 0);
    check("t5.fall_before_7th", 32'(fl1), 32'd0);
    send("t5", 50, 0);
    check("t5.fall_at_7th", 32'(fl1), 32'd1);

    // Randomized level steps with noise, gaps and occasional clears
    lvl = 100;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 149) == 0) do_clear(1'($urandom_range(0, 1)));
      if (i % 20 == 0) lvl = $urandom_range(30, 220);
      s = lvl + $urandom_range(0, 20) - 10;
      if (s < 0) s = 0;
      if (s > 255) s = 255;
      send("rand", s, $urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
